// File: rtl/snake_pkg.sv
// snake_pkg: playfield geometry and scanner state type shared by map readers.
package snake_pkg;
    localparam int GRID_W = 14;
    localparam int GRID_H = 10;
    typedef logic [3:0] coord_t;
    typedef enum logic [1:0] {IDLE, QUERY, EMIT, DONE} scan_state_t;
endpackage

// File: rtl/grid_walker.sv
// grid_walker: row-major raster counter over a W x H playfield, parked at (0,0) when idle.
module grid_walker
    import snake_pkg::*;
#(
    parameter int W = GRID_W,
    parameter int H = GRID_H
) (
    input  logic   clk,
    input  logic   nRst,
    input  logic   park,
    input  logic   clear,
    input  logic   step,
    output coord_t x,
    output coord_t y,
    output logic   last
);
    logic row_end;

    assign row_end = x == coord_t'(W);
    assign last    = row_end && y == coord_t'(H);

    // park wins over clear so an abort always leaves the counter at (0,0)
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            x <= '0;
            y <= '0;
        end else if (park) begin
            x <= '0;
            y <= '0;
        end else if (clear) begin
            x <= coord_t'(1);
            y <= coord_t'(1);
        end else if (step) begin
            x <= row_end ? coord_t'(1) : x + coord_t'(1);
            y <= row_end ? y + coord_t'(1) : y;
        end
    end
endmodule

// File: rtl/obstacle_scanner.sv
// obstacle_scanner: sweeps every playfield cell through the obstacle generator,
// streams {x, y, obs} records over valid/ready and checks the obstacle total.
module obstacle_scanner
    import snake_pkg::*;
#(
    parameter int GRID_W = snake_pkg::GRID_W,
    parameter int GRID_H = snake_pkg::GRID_H
) (
    input  logic       clk,
    input  logic       nRst,
    input  logic       start,
    input  logic       abort,
    input  logic       obstacle,
    input  logic [3:0] obstacleCount,
    output coord_t     x,
    output coord_t     y,
    output logic       cell_valid,
    input  logic       cell_ready,
    output coord_t     cell_x,
    output coord_t     cell_y,
    output logic       cell_obs,
    output logic       busy,
    output logic       done,
    output logic [7:0] found,
    output logic       mismatch
);
    scan_state_t state, state_next;
    logic walk_clear, walk_step, walk_park, walk_last;

    grid_walker #(.W(GRID_W), .H(GRID_H)) u_walker (
        .clk  (clk),
        .nRst (nRst),
        .park (walk_park),
        .clear(walk_clear),
        .step (walk_step),
        .x    (x),
        .y    (y),
        .last (walk_last)
    );

    always_comb begin
        state_next = state;
        walk_clear = 1'b0;
        walk_step  = 1'b0;
        case (state)
            IDLE: begin
                state_next = start ? QUERY : IDLE;
                walk_clear = start;
            end
            QUERY: state_next = EMIT;
            EMIT: begin
                state_next = cell_ready ? (walk_last ? DONE : QUERY) : EMIT;
                walk_step  = cell_ready && !walk_last;
            end
            default: state_next = IDLE;
        endcase
        if (abort) begin
            state_next = IDLE;
            walk_clear = 1'b0;
            walk_step  = 1'b0;
        end
        walk_park = state_next == IDLE;
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state      <= IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            cell_valid <= 1'b0;
            cell_x     <= '0;
            cell_y     <= '0;
            cell_obs   <= 1'b0;
            found      <= '0;
            mismatch   <= 1'b0;
        end else begin
            state      <= state_next;
            busy       <= state_next != IDLE;
            done       <= state_next == DONE;
            cell_valid <= state_next == EMIT;
            if (state == QUERY && !abort) begin
                cell_x   <= x;
                cell_y   <= y;
                cell_obs <= obstacle;
                found    <= found + {7'b0, obstacle};
            end
            if (walk_clear) begin
                found    <= '0;
                mismatch <= 1'b0;
            end
            // found is final once the last record is accepted, so the check lands on DONE entry
            if (state == EMIT && state_next == DONE)
                mismatch <= found != {4'b0, obstacleCount};
        end
    end
endmodule

// File: tb/tb_obstacle_scanner.sv
// tb_obstacle_scanner: directed checks of sweep order, obstacle count check,
// backpressure, abort and asynchronous reset of obstacle_scanner.
module tb_obstacle_scanner;
    import snake_pkg::*;

    logic       clk = 1'b0;
    logic       nRst = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       cell_ready = 1'b0;
    logic [3:0] obstacleCount = '0;
    logic       obstacle;
    coord_t     x, y, cell_x, cell_y;
    logic       cell_valid, cell_obs, busy, done, mismatch;
    logic [7:0] found;
    logic       map_on = 1'b0;
    int         n_assert = 0;
    int         n_fail = 0;

    obstacle_scanner dut (
        .clk(clk), .nRst(nRst), .start(start), .abort(abort), .obstacle(obstacle),
        .obstacleCount(obstacleCount), .x(x), .y(y), .cell_valid(cell_valid),
        .cell_ready(cell_ready), .cell_x(cell_x), .cell_y(cell_y), .cell_obs(cell_obs),
        .busy(busy), .done(done), .found(found), .mismatch(mismatch)
    );

    always #5 clk = ~clk;

    function automatic logic is_obs(input logic [3:0] cx, input logic [3:0] cy);
        return (cx == 4'd3 && cy == 4'd2) || (cx == 4'd14 && cy == 4'd1) || (cx == 4'd1 && cy == 4'd10);
    endfunction

    assign obstacle = map_on && is_obs(x, y);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_x"}, x, 0);
        chk({tag, "_y"}, y, 0);
        chk({tag, "_cx"}, cell_x, 0);
        chk({tag, "_cy"}, cell_y, 0);
        chk({tag, "_cobs"}, cell_obs, 0);
        chk({tag, "_valid"}, cell_valid, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_mis"}, mismatch, 0);
        chk({tag, "_found"}, found, 0);
    endtask

    task automatic sweep(input logic rnd, input logic [3:0] cnt, input logic [7:0] exp_found,
                         input logic exp_mis);
        int recs = 0;
        int done_cyc = 0;
        logic [3:0] ex = 4'd1;
        logic [3:0] ey = 4'd1;
        obstacleCount = cnt;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("q1_busy", busy, 1);
        chk("q1_x", x, 1);
        chk("q1_y", y, 1);
        chk("q1_found", found, 0);
        chk("q1_mis", mismatch, 0);
        chk("q1_valid", cell_valid, 0);
        for (int cyc = 1; cyc < 3000 && done_cyc == 0; cyc++) begin
            cell_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (done) done_cyc = cyc;
            if (busy && !done) begin
                if (x !== ex || y !== ey) chk("walk_xy", {x, y}, {ex, ey});
            end
            if (cell_valid) begin
                if (cell_x !== ex || cell_y !== ey) chk("rec_xy", {cell_x, cell_y}, {ex, ey});
                if (cell_obs !== (map_on && is_obs(ex, ey))) chk("rec_obs", cell_obs, map_on && is_obs(ex, ey));
                if (cell_ready) begin
                    recs++;
                    ey = (ex == 4'd14) ? ey + 4'd1 : ey;
                    ex = (ex == 4'd14) ? 4'd1 : ex + 4'd1;
                end
            end
            @(posedge clk); #1;
        end
        cell_ready = 1'b0;
        chk("done_seen", done_cyc != 0, 1);
        if (!rnd) chk("done_cycle", done_cyc, 281);
        chk("records", recs, 140);
        chk("found", found, exp_found);
        chk("mismatch", mismatch, exp_mis);
        chk("idle_busy", busy, 0);
        chk("idle_done", done, 0);
        chk("idle_x", x, 0);
    endtask

    initial begin
        int guard;
        repeat (2) @(posedge clk);
        #1 chk_reset("rst");
        nRst = 1'b1;
        @(posedge clk); #1;

        sweep(1'b0, 4'd0, 8'd0, 1'b0);
        map_on = 1'b1;
        sweep(1'b0, 4'd3, 8'd3, 1'b0);
        sweep(1'b0, 4'd4, 8'd3, 1'b1);
        sweep(1'b1, 4'd3, 8'd3, 1'b0);

        // abort at cell (7,4)
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cell_ready = 1'b1;
        guard = 0;
        while (!(cell_valid && x == 4'd7 && y == 4'd4) && guard < 400) begin
            @(posedge clk); #1;
            guard++;
        end
        chk("abort_reach", guard < 400, 1);
        chk("abort_found_pre", found, 2);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_valid", cell_valid, 0);
        chk("abort_x", x, 0);
        chk("abort_found", found, 2);
        for (int i = 0; i < 4; i++) begin
            chk("abort_nodone", done, 0);
            @(posedge clk); #1;
        end
        sweep(1'b0, 4'd3, 8'd3, 1'b0);

        // abort overrides start in IDLE
        start = 1'b1;
        abort = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        abort = 1'b0;
        chk("abort_start_busy", busy, 0);
        chk("abort_start_found", found, 3);

        // asynchronous reset mid-sweep with start held
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cell_ready = 1'b1;
        repeat (20) @(posedge clk);
        #3;
        start = 1'b1;
        nRst = 1'b0;
        #1 chk_reset("arst");
        @(posedge clk); #1;
        chk_reset("arst_hold");
        nRst = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("arst_busy", busy, 1);
        chk("arst_x", x, 1);
        chk("arst_y", y, 1);
        guard = 0;
        while (!done && guard < 400) begin
            @(posedge clk); #1;
            guard++;
        end
        chk("arst_done_seen", done, 1);
        chk("arst_found", found, 3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
